// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational multiplier
// among NREQ requesters. Operands are registered onto the multiplier inputs,
// the product is given SETTLE_CYC cycles to settle, then captured into a
// held response that stays stable until the consumer takes it.
module mult_share_arbiter #(
  parameter int WIDTH      = 16,
  parameter int OUTWIDTH   = 32,
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_in1,
  output logic [WIDTH-1:0]      mul_in2,
  input  logic [OUTWIDTH-1:0]   mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUTWIDTH-1:0]   rsp_p,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  // Settle counter holds values 0..SETTLE_CYC-1.
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic              found;
  logic              accept;
  logic              capture;
  logic              release_rsp;
  logic [SC_W-1:0]   cnt;

  // Requester index (base + off) modulo NREQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return ID_W'(s % NREQ);
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!found && req_valid[wrap_add(rr_ptr, off)]) begin
        grant = wrap_add(rr_ptr, off);
        found = 1'b1;
      end
    end
  end

  // Next-state logic and the one-hot accept strobe (held off during reset).
  always_comb begin
    state_next  = state;
    req_ready   = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_next       = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand launch, settle countdown, product capture and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_in1   <= '0;
      mul_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        mul_in1 <= req_a[grant*WIDTH +: WIDTH];
        mul_in2 <= req_b[grant*WIDTH +: WIDTH];
        rsp_id  <= grant;
        rr_ptr  <= wrap_add(grant, 1);
        cnt     <= SC_W'(SETTLE_CYC - 1);
      end
      if (state == SETTLE && !capture) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_p     <= mul_p;
        rsp_valid <= 1'b1;
      end
      if (release_rsp) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: instance A uses SETTLE_CYC=1, CNT_W=16;
// instance B uses SETTLE_CYC=3, CNT_W=4. Each drives an exact-multiply model
// on its mul_p and keeps a queue of expected (id, product) responses.
module tb_mult_share_arbiter;
  localparam int WIDTH    = 16;
  localparam int OUTWIDTH = 32;
  localparam int NREQ     = 4;
  localparam int ID_W     = 2;

  typedef struct {
    logic [ID_W-1:0]     id;
    logic [OUTWIDTH-1:0] p;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  a_rst_n, b_rst_n;
  logic [NREQ-1:0]       a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [NREQ*WIDTH-1:0] a_req_a, a_req_b, b_req_a, b_req_b;
  logic [WIDTH-1:0]      a_mul_in1, a_mul_in2, b_mul_in1, b_mul_in2;
  logic [OUTWIDTH-1:0]   a_mul_p, a_rsp_p, b_mul_p, b_rsp_p;
  logic                  a_rsp_valid, a_rsp_ready, a_busy;
  logic                  b_rsp_valid, b_rsp_ready, b_busy;
  logic [ID_W-1:0]       a_rsp_id, b_rsp_id;
  logic [15:0]           a_op_count;
  logic [3:0]            b_op_count;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int ready_viol = 0;

  assign a_mul_p = OUTWIDTH'(a_mul_in1) * OUTWIDTH'(a_mul_in2);
  assign b_mul_p = OUTWIDTH'(b_mul_in1) * OUTWIDTH'(b_mul_in2);

  mult_share_arbiter #(
    .WIDTH(WIDTH), .OUTWIDTH(OUTWIDTH), .NREQ(NREQ), .ID_W(ID_W),
    .SETTLE_CYC(1), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a(a_req_a), .req_b(a_req_b), .mul_in1(a_mul_in1), .mul_in2(a_mul_in2),
    .mul_p(a_mul_p), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_p(a_rsp_p), .rsp_id(a_rsp_id), .busy(a_busy), .op_count(a_op_count)
  );

  mult_share_arbiter #(
    .WIDTH(WIDTH), .OUTWIDTH(OUTWIDTH), .NREQ(NREQ), .ID_W(ID_W),
    .SETTLE_CYC(3), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .mul_in1(b_mul_in1), .mul_in2(b_mul_in2),
    .mul_p(b_mul_p), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_p(b_rsp_p), .rsp_id(b_rsp_id), .busy(b_busy), .op_count(b_op_count)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!$onehot0(a_req_ready) || !$onehot0(b_req_ready)) ready_viol++;
  end

  function automatic logic [OUTWIDTH-1:0] prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return OUTWIDTH'(x) * OUTWIDTH'(y);
  endfunction

  task automatic set_op_a(input int i, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a_req_a[i*WIDTH +: WIDTH] = av;
    a_req_b[i*WIDTH +: WIDTH] = bv;
  endtask

  task automatic set_op_b(input int i, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    b_req_a[i*WIDTH +: WIDTH] = av;
    b_req_b[i*WIDTH +: WIDTH] = bv;
  endtask

  // Advance at least one negedge, stop when rsp_valid is seen or the budget runs out.
  task automatic wait_a(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (a_rsp_valid !== 1'b1 && lat < 40);
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (b_rsp_valid !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req_valid = '1; b_req_valid = '1;
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    a_req_a = '0; a_req_b = '0; b_req_a = '0; b_req_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_mul_in1, a_mul_in2, a_rsp_valid, a_rsp_p, a_rsp_id, a_busy, a_op_count} !== '0)
      $display("FAIL reset_a_outputs: got in1=%0h in2=%0h v=%b p=%0h id=%0d busy=%b cnt=%0d, expected all 0",
               a_mul_in1, a_mul_in2, a_rsp_valid, a_rsp_p, a_rsp_id, a_busy, a_op_count);
    else passed++;
    checks++;
    if ({b_mul_in1, b_mul_in2, b_rsp_valid, b_rsp_p, b_rsp_id, b_busy, b_op_count} !== '0)
      $display("FAIL reset_b_outputs: got in1=%0h in2=%0h v=%b p=%0h id=%0d busy=%b cnt=%0d, expected all 0",
               b_mul_in1, b_mul_in2, b_rsp_valid, b_rsp_p, b_rsp_id, b_busy, b_op_count);
    else passed++;
    checks++;
    if ({a_req_ready, b_req_ready} !== 8'h00)
      $display("FAIL reset_ready: got a=%b b=%b, expected 0000 0000", a_req_ready, b_req_ready);
    else passed++;
    a_req_valid = '0; b_req_valid = '0;
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e; int lat;
    @(negedge clk);
    set_op_a(0, 16'd3, 16'd5);
    a_req_valid = 4'b0001; a_rsp_ready = 1'b1;
    q_a.push_back('{id: 2'd0, p: prod(16'd3, 16'd5)});
    #1;
    checks++;
    if (a_req_ready !== 4'b0001) $display("FAIL basic_ready: got %b expected 0001", a_req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = '0;
    checks++;
    if ({a_busy, a_rsp_valid, a_mul_in1, a_mul_in2} !== {1'b1, 1'b0, 16'd3, 16'd5})
      $display("FAIL basic_settle: got busy=%b v=%b in1=%0d in2=%0d expected 1 0 3 5",
               a_busy, a_rsp_valid, a_mul_in1, a_mul_in2);
    else passed++;
    wait_a(lat);
    checks++;
    if (lat + 1 !== 2) begin
      $display("FAIL basic_latency: got %0d cycles expected 2", lat + 1);
      return;
    end
    passed++;
    e = q_a.pop_front();
    checks++;
    if ({a_rsp_id, a_rsp_p} !== {e.id, e.p})
      $display("FAIL basic_rsp: got id=%0d p=%0h expected id=%0d p=%0h", a_rsp_id, a_rsp_p, e.id, e.p);
    else passed++;
    @(negedge clk);
    checks++;
    if ({a_op_count, a_rsp_valid, a_busy} !== {16'd1, 1'b0, 1'b0})
      $display("FAIL basic_done: got cnt=%0d v=%b busy=%b expected 1 0 0", a_op_count, a_rsp_valid, a_busy);
    else passed++;
  endtask

  task automatic test_fairness();
    exp_t e; int lat; int prev;
    @(negedge clk); a_rst_n = 1'b0; a_req_valid = '0;
    @(negedge clk); a_rst_n = 1'b1; q_a.delete();
    for (int i = 0; i < NREQ; i++) set_op_a(i, 16'(10 + i), 16'(3 * i + 7));
    for (int n = 0; n < 6; n++)
      q_a.push_back('{id: ID_W'(n % NREQ), p: prod(16'(10 + n % NREQ), 16'(3 * (n % NREQ) + 7))});
    a_rsp_ready = 1'b1; a_req_valid = '1; prev = 0;
    for (int n = 0; n < 6; n++) begin
      wait_a(lat);
      checks++;
      if (a_rsp_valid !== 1'b1) begin
        $display("FAIL fair_timeout: op %0d rsp_valid=%b expected 1", n, a_rsp_valid);
        a_req_valid = '0;
        return;
      end
      passed++;
      e = q_a.pop_front();
      checks++;
      if ({a_rsp_id, a_rsp_p} !== {e.id, e.p})
        $display("FAIL fair_rsp: op %0d got id=%0d p=%0h expected id=%0d p=%0h", n, a_rsp_id, a_rsp_p, e.id, e.p);
      else passed++;
      if (n > 0) begin
        checks++;
        if (cyc - prev !== 3) $display("FAIL fair_spacing: op %0d got %0d cycles expected 3", n, cyc - prev);
        else passed++;
      end
      prev = cyc;
      if (n == 5) a_req_valid = '0;
    end
    @(negedge clk);
    checks++;
    if (a_op_count !== 16'd6) $display("FAIL fair_count: got %0d expected 6", a_op_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    exp_t e; int lat;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    set_op_a(0, 16'hFFFF, 16'hFFFF);
    set_op_a(1, 16'h1234, 16'h0010);
    a_req_valid = 4'b0011;
    // rr_ptr sits at 2 after the last grant to requester 1, so requester 0 wins first.
    q_a.push_back('{id: 2'd0, p: 32'hFFFE0001});
    q_a.push_back('{id: 2'd1, p: prod(16'h1234, 16'h0010)});
    #1;
    checks++;
    if (a_req_ready !== 4'b0001) $display("FAIL bp_ready: got %b expected 0001", a_req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 4'b0010;
    wait_a(lat);
    checks++;
    if (a_rsp_valid !== 1'b1) begin
      $display("FAIL bp_timeout: rsp_valid=%b expected 1", a_rsp_valid);
      a_req_valid = '0;
      return;
    end
    passed++;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({a_rsp_valid, a_rsp_id, a_rsp_p, a_req_ready} !== {1'b1, 2'd0, 32'hFFFE0001, 4'b0000})
        $display("FAIL bp_hold: cycle %0d got v=%b id=%0d p=%0h ready=%b expected 1 0 fffe0001 0000",
                 k, a_rsp_valid, a_rsp_id, a_rsp_p, a_req_ready);
      else passed++;
      @(negedge clk);
    end
    e = q_a.pop_front();
    checks++;
    if ({a_rsp_valid, a_rsp_id, a_rsp_p} !== {1'b1, e.id, e.p})
      $display("FAIL bp_rsp: got v=%b id=%0d p=%0h expected 1 %0d %0h", a_rsp_valid, a_rsp_id, a_rsp_p, e.id, e.p);
    else passed++;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_rsp_valid, a_req_ready, a_op_count} !== {1'b0, 4'b0010, 16'd7})
      $display("FAIL bp_release: got v=%b ready=%b cnt=%0d expected 0 0010 7", a_rsp_valid, a_req_ready, a_op_count);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = '0;
    wait_a(lat);
    checks++;
    if (a_rsp_valid !== 1'b1) begin
      $display("FAIL bp_timeout2: rsp_valid=%b expected 1", a_rsp_valid);
      return;
    end
    passed++;
    e = q_a.pop_front();
    checks++;
    if ({a_rsp_id, a_rsp_p} !== {e.id, e.p})
      $display("FAIL bp_rsp2: got id=%0d p=%0h expected id=%0d p=%0h", a_rsp_id, a_rsp_p, e.id, e.p);
    else passed++;
    @(negedge clk);
    checks++;
    if (a_op_count !== 16'd8) $display("FAIL bp_count: got %0d expected 8", a_op_count);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    exp_t e; int lat;
    @(negedge clk);
    set_op_a(3, 16'h00AB, 16'h0102);
    a_req_valid = 4'b1000;
    #1;
    checks++;
    if (a_req_ready !== 4'b1000) $display("FAIL rst_mid_ready: got %b expected 1000", a_req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = '0;
    checks++;
    if (a_busy !== 1'b1) $display("FAIL rst_mid_busy: got %b expected 1", a_busy);
    else passed++;
    // The in-flight operation is discarded, so nothing is queued for it.
    a_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_mul_in1, a_mul_in2, a_rsp_valid, a_rsp_p, a_rsp_id, a_busy, a_op_count} !== '0)
      $display("FAIL rst_mid_zero: got in1=%0h in2=%0h v=%b p=%0h id=%0d busy=%b cnt=%0d, expected all 0",
               a_mul_in1, a_mul_in2, a_rsp_valid, a_rsp_p, a_rsp_id, a_busy, a_op_count);
    else passed++;
    @(negedge clk);
    a_req_valid = '1;
    #1;
    checks++;
    if (a_req_ready !== 4'b0000) $display("FAIL rst_mid_forced: got %b expected 0000", a_req_ready);
    else passed++;
    @(negedge clk);
    a_rst_n = 1'b1;
    q_a.push_back('{id: 2'd0, p: 32'hFFFE0001});
    #1;
    checks++;
    if (a_req_ready !== 4'b0001) $display("FAIL rst_mid_grant: got %b expected 0001", a_req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = '0;
    wait_a(lat);
    checks++;
    if (a_rsp_valid !== 1'b1) begin
      $display("FAIL rst_mid_timeout: rsp_valid=%b expected 1", a_rsp_valid);
      return;
    end
    passed++;
    e = q_a.pop_front();
    checks++;
    if ({a_rsp_id, a_rsp_p} !== {e.id, e.p})
      $display("FAIL rst_mid_rsp: got id=%0d p=%0h expected id=%0d p=%0h", a_rsp_id, a_rsp_p, e.id, e.p);
    else passed++;
    @(negedge clk);
    checks++;
    if (a_op_count !== 16'd1) $display("FAIL rst_mid_count: got %0d expected 1", a_op_count);
    else passed++;
  endtask

  task automatic test_settle3();
    exp_t e; int lat;
    @(negedge clk);
    set_op_b(2, 16'd100, 16'd200);
    b_req_valid = 4'b0100; b_rsp_ready = 1'b1;
    q_b.push_back('{id: 2'd2, p: 32'd20000});
    #1;
    checks++;
    if (b_req_ready !== 4'b0100) $display("FAIL s3_ready: got %b expected 0100", b_req_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = '0;
    wait_b(lat);
    checks++;
    if (lat + 1 !== 4) begin
      $display("FAIL s3_latency: got %0d cycles expected 4", lat + 1);
      return;
    end
    passed++;
    e = q_b.pop_front();
    checks++;
    if ({b_rsp_id, b_rsp_p} !== {e.id, e.p})
      $display("FAIL s3_rsp: got id=%0d p=%0d expected id=%0d p=%0d", b_rsp_id, b_rsp_p, e.id, e.p);
    else passed++;
    @(negedge clk);
    checks++;
    if (b_op_count !== 4'd1) $display("FAIL s3_count: got %0d expected 1", b_op_count);
    else passed++;
  endtask

  task automatic test_counter_wrap();
    exp_t e; int lat; int prev;
    @(negedge clk); b_rst_n = 1'b0; b_req_valid = '0;
    @(negedge clk); b_rst_n = 1'b1; q_b.delete();
    for (int i = 0; i < NREQ; i++) set_op_b(i, 16'(500 + 17 * i), 16'(1000 - 31 * i));
    for (int n = 0; n < 17; n++)
      q_b.push_back('{id: ID_W'(n % NREQ), p: prod(16'(500 + 17 * (n % NREQ)), 16'(1000 - 31 * (n % NREQ)))});
    b_rsp_ready = 1'b1; b_req_valid = '1; prev = 0;
    for (int n = 0; n < 17; n++) begin
      wait_b(lat);
      checks++;
      if (b_rsp_valid !== 1'b1) begin
        $display("FAIL wrap_timeout: op %0d rsp_valid=%b expected 1", n, b_rsp_valid);
        b_req_valid = '0;
        return;
      end
      passed++;
      e = q_b.pop_front();
      checks++;
      if ({b_rsp_id, b_rsp_p, b_op_count} !== {e.id, e.p, 4'(n)})
        $display("FAIL wrap_rsp: op %0d got id=%0d p=%0h cnt=%0d expected id=%0d p=%0h cnt=%0d",
                 n, b_rsp_id, b_rsp_p, b_op_count, e.id, e.p, 4'(n));
      else passed++;
      if (n > 0) begin
        checks++;
        if (cyc - prev !== 5) $display("FAIL wrap_spacing: op %0d got %0d cycles expected 5", n, cyc - prev);
        else passed++;
      end
      prev = cyc;
      if (n == 16) b_req_valid = '0;
    end
    @(negedge clk);
    checks++;
    if (b_op_count !== 4'd1) $display("FAIL wrap_count: got %0d expected 1", b_op_count);
    else passed++;
  endtask

  task automatic test_onehot();
    checks++;
    if (ready_viol !== 0) $display("FAIL ready_onehot: got %0d violations expected 0", ready_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
    test_settle3();
    test_counter_wrap();
    test_onehot();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

endmodule
